axil_mem_slave: RTL
===================

Name: axil_mem_slave

Overview:
- AXI4-Lite slave front end for the 128-byte Memory block: accepts AXI write and read transactions and drives the Memory port (CS, WE, WADDR, RADDR, Mem_in), capturing read data from Mem_out.
- Word-aligned 32-bit accesses only.
- Partial-strobe writes are done as read-modify-write.
- Sits between the AXI interconnect and the Memory instance.

Parameters:
- ADDR_WIDTH, 7: byte address width, matches Memory WADDR/RADDR.
- DATA_WIDTH, 32: data width; only 32 is supported.
- WRITE_FIRST, 1: when write and read requests are pending in the same IDLE cycle, 1 = write wins, 0 = read wins.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESETn  in  1  asynchronous active-low reset.
- AWADDR  in  7  write address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address accepted.
- WDATA  in  32  write data.
- WSTRB  in  4  byte strobes; bit i covers WDATA[8i+7:8i].
- WVALID  in  1  write data valid.
- WREADY  out  1  write data accepted.
- BRESP  out  2  write response: 00 = OKAY, 10 = SLVERR.
- BVALID  out  1  write response valid.
- BREADY  in  1  master ready for write response.
- ARADDR  in  7  read address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address accepted.
- RDATA  out  32  read data.
- RRESP  out  2  read response.
- RVALID  out  1  read data valid.
- RREADY  in  1  master ready for read data.
- MEM_CS  out  1  Memory chip select.
- MEM_WE  out  1  Memory write enable.
- MEM_WADDR  out  7  Memory write byte address.
- MEM_RADDR  out  7  Memory read byte address.
- MEM_WDATA  out  32  to Memory Mem_in.
- MEM_RDATA  in  32  from Memory Mem_out.

Behaviour:
- Reset (async, RESETn = 0):
  - All outputs 0.
  - FSM returns to IDLE; any in-flight transaction is dropped with no response.
  - MEM_WE falls immediately, so no Memory write occurs on the following negedge.
- Memory timing: Memory samples and writes on negedge CLK, and Mem_out is registered on negedge. All MEM_* outputs are registered on posedge, so data read at negedge N is captured at posedge N+1.
- States: IDLE, RMW_RD, WR_COMMIT, WR_RESP, RD_WAIT, RD_RESP.
- IDLE:
  - AWREADY = WREADY = (AWVALID & WVALID & write selected).
  - ARREADY = (ARVALID & read selected).
  - Write handshake needs AWVALID and WVALID in the same cycle; AW and W are accepted together.
  - Selection follows WRITE_FIRST when both are pending.
  - All READY signals are 0 outside IDLE; one outstanding transaction at a time.
- Write with misaligned address (AWADDR[1:0] != 0) or WSTRB = 0:
  - No Memory access.
  - Next posedge: BVALID = 1, BRESP = SLVERR if misaligned, else OKAY; go to WR_RESP.
- Write with WSTRB = 4'hF:
  - At the handshake edge: MEM_WADDR = AWADDR, MEM_WDATA = WDATA, MEM_CS = MEM_WE = 1; go to WR_COMMIT.
  - Next posedge: MEM_CS = MEM_WE = 0, BVALID = 1, BRESP = OKAY; go to WR_RESP.
  - Latency: 1 cycle from handshake to BVALID.
- Write with partial strobe:
  - At the handshake edge: MEM_RADDR = AWADDR, MEM_CS = 1, MEM_WE = 0; latch WDATA and WSTRB; go to RMW_RD.
  - Next posedge: MEM_WDATA = per-byte merge (strobe 1 → WDATA byte, 0 → MEM_RDATA byte), MEM_WADDR = AWADDR, MEM_WE = 1; go to WR_COMMIT.
  - Then as the full-strobe case. Latency: 2 cycles.
- WR_RESP: hold BVALID and BRESP until BREADY; on BVALID & BREADY, BVALID = 0 and go to IDLE.
- Read:
  - At the handshake edge: MEM_RADDR = ARADDR, MEM_CS = 1; go to RD_WAIT.
  - Next posedge: RDATA = MEM_RDATA, RRESP = OKAY, RVALID = 1, MEM_CS = 0; go to RD_RESP.
  - Misaligned ARADDR: no Memory access; RDATA = 0, RRESP = SLVERR, RVALID next posedge.
- RD_RESP: hold RDATA, RRESP, RVALID stable until RREADY; on RVALID & RREADY go to IDLE.
- Addresses: highest legal word is 124 (bytes 124..127); no wrap-around is possible for aligned addresses.
- Back-to-back: a new handshake is accepted only in the IDLE cycle after the response completes (minimum 3-cycle period for full writes).
- RESETn deasserted mid-response: the response is lost and the master must reissue.

Test Plan:
- Reset: RESETn = 0 mid-WR_COMMIT → all outputs 0 immediately; Memory byte 0x10 unchanged.
- Full write then read: write 0x10 ← 0xDEADBEEF, WSTRB = F → BVALID 1 cycle after the handshake, BRESP = 00; read 0x10 → RVALID 1 cycle after ARREADY, RDATA = 0xDEADBEEF, RRESP = 00.
- Partial write: preload 0x20 = 0x11223344; write 0xAABBCCDD, WSTRB = 0101 → BVALID 2 cycles after the handshake; read 0x20 → 0x11BB33DD.
- Misaligned access: write to 0x13 → BRESP = 10 and Memory unchanged; read 0x7D → RDATA = 0, RRESP = 10.
- Backpressure and arbitration: hold BREADY = 0 for 5 cycles → BVALID and BRESP stable, ARREADY = 0 throughout. Assert AW/W/AR together with WRITE_FIRST = 1 → write is serviced first, read is accepted in the IDLE cycle after the B handshake.
- Boundary: write and read address 124 → data round-trips correctly; WSTRB = 0 → BRESP = 00 with no Memory write.

Source files
------------

// File: rtl/axil_mem_slave.sv
// AXI4-Lite slave front end for the 128-byte Memory block. Handles one
// transaction at a time; partial-strobe writes go through a read-modify-write.
module axil_mem_slave #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 32,
    parameter int WRITE_FIRST = 1
) (
    input  logic                    CLK,
    input  logic                    RESETn,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic                    MEM_CS,
    output logic                    MEM_WE,
    output logic [ADDR_WIDTH-1:0]   MEM_WADDR,
    output logic [ADDR_WIDTH-1:0]   MEM_RADDR,
    output logic [DATA_WIDTH-1:0]   MEM_WDATA,
    input  logic [DATA_WIDTH-1:0]   MEM_RDATA
);

    localparam int STRB_W = DATA_WIDTH / 8;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RMW_RD    = 3'd1;
    localparam logic [2:0] S_WR_COMMIT = 3'd2;
    localparam logic [2:0] S_WR_RESP   = 3'd3;
    localparam logic [2:0] S_RD_WAIT   = 3'd4;
    localparam logic [2:0] S_RD_RESP   = 3'd5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [2:0]            state_q, state_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  mem_cs_q, mem_cs_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_waddr_q, mem_waddr_d;
    logic [ADDR_WIDTH-1:0] mem_raddr_q, mem_raddr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;

    logic                  wr_req, wr_sel, rd_sel, idle, wr_go, rd_go;
    logic [DATA_WIDTH-1:0] merged;

    // Ready is gated by reset as well so every output reads 0 while held in reset.
    assign idle   = (state_q == S_IDLE) && RESETn;
    assign wr_req = AWVALID && WVALID;
    assign wr_sel = wr_req && ((WRITE_FIRST != 0) || !ARVALID);
    assign rd_sel = ARVALID && ((WRITE_FIRST == 0) || !wr_req);
    assign wr_go  = idle && wr_sel;
    assign rd_go  = idle && rd_sel;

    assign AWREADY   = wr_go;
    assign WREADY    = wr_go;
    assign ARREADY   = rd_go;
    assign BVALID    = bvalid_q;
    assign BRESP     = bresp_q;
    assign RVALID    = rvalid_q;
    assign RRESP     = rresp_q;
    assign RDATA     = rdata_q;
    assign MEM_CS    = mem_cs_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_WADDR = mem_waddr_q;
    assign MEM_RADDR = mem_raddr_q;
    assign MEM_WDATA = mem_wdata_q;

    always_comb begin
        merged = MEM_RDATA;
        for (int i = 0; i < STRB_W; i++) begin
            if (wstrb_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        rvalid_d    = rvalid_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        mem_cs_d    = mem_cs_q;
        mem_we_d    = mem_we_q;
        mem_waddr_d = mem_waddr_q;
        mem_raddr_d = mem_raddr_q;
        mem_wdata_d = mem_wdata_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        case (state_q)
            S_IDLE: begin
                if (wr_go) begin
                    if ((|AWADDR[1:0]) || (WSTRB == '0)) begin
                        bvalid_d = 1'b1;
                        bresp_d  = (|AWADDR[1:0]) ? RESP_SLVERR : RESP_OKAY;
                        state_d  = S_WR_RESP;
                    end else if (WSTRB == '1) begin
                        mem_waddr_d = AWADDR;
                        mem_wdata_d = WDATA;
                        mem_cs_d    = 1'b1;
                        mem_we_d    = 1'b1;
                        state_d     = S_WR_COMMIT;
                    end else begin
                        // mem_raddr_q keeps the target address for the commit cycle.
                        mem_raddr_d = AWADDR;
                        mem_cs_d    = 1'b1;
                        mem_we_d    = 1'b0;
                        wdata_d     = WDATA;
                        wstrb_d     = WSTRB;
                        state_d     = S_RMW_RD;
                    end
                end else if (rd_go) begin
                    if (|ARADDR[1:0]) begin
                        rdata_d  = '0;
                        rresp_d  = RESP_SLVERR;
                        rvalid_d = 1'b1;
                        state_d  = S_RD_RESP;
                    end else begin
                        mem_raddr_d = ARADDR;
                        mem_cs_d    = 1'b1;
                        state_d     = S_RD_WAIT;
                    end
                end
            end
            S_RMW_RD: begin
                mem_wdata_d = merged;
                mem_waddr_d = mem_raddr_q;
                mem_we_d    = 1'b1;
                state_d     = S_WR_COMMIT;
            end
            S_WR_COMMIT: begin
                mem_cs_d = 1'b0;
                mem_we_d = 1'b0;
                bvalid_d = 1'b1;
                bresp_d  = RESP_OKAY;
                state_d  = S_WR_RESP;
            end
            S_WR_RESP: begin
                if (BREADY) begin
                    bvalid_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            S_RD_WAIT: begin
                rdata_d  = MEM_RDATA;
                rresp_d  = RESP_OKAY;
                rvalid_d = 1'b1;
                mem_cs_d = 1'b0;
                state_d  = S_RD_RESP;
            end
            S_RD_RESP: begin
                if (RREADY) begin
                    rvalid_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= S_IDLE;
            bvalid_q    <= 1'b0;
            bresp_q     <= '0;
            rvalid_q    <= 1'b0;
            rresp_q     <= '0;
            rdata_q     <= '0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_raddr_q <= '0;
            mem_wdata_q <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            state_q     <= state_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            rvalid_q    <= rvalid_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            mem_cs_q    <= mem_cs_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_raddr_q <= mem_raddr_d;
            mem_wdata_q <= mem_wdata_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
        end
    end

endmodule
